cache_fill_ctrl: RTL and testbench

CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

---
 rtl/cache_fill_ctrl.sv | 106 ++++++++++
 tb/tb_cache_fill_ctrl.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_fill_ctrl.sv
// Cache line fill controller: on a miss, issues pipelined word reads for the
// whole line (bounded outstanding count), writes returned words, then the tag.
module cache_fill_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned LINE_WORDS = 8,
  parameter int unsigned MAX_OUTST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          miss_detected,
  input  logic [ADDR_W-1:0]             miss_address,
  output logic                          mem_req,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic                          mem_ready,
  input  logic                          mem_data_valid,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          fsm_busy,
  output logic                          fsm_data_wen,
  output logic [$clog2(LINE_WORDS)-1:0] fsm_word_idx,
  output logic [DATA_W-1:0]             fsm_data,
  output logic                          fsm_tag_wen,
  output logic [ADDR_W-1:0]             fill_base
);

  localparam int unsigned IDX_W      = $clog2(LINE_WORDS);
  localparam int unsigned CNT_W      = IDX_W + 1;
  localparam int unsigned WORD_BYTES = DATA_W / 8;
  localparam int unsigned OFF_W      = $clog2(LINE_WORDS * WORD_BYTES);

  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((64'd1 << OFF_W) - 64'd1);
  localparam logic [CNT_W-1:0]  LINE_CNT  = CNT_W'(LINE_WORDS);
  localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(LINE_WORDS - 1);
  localparam logic [CNT_W-1:0]  OUTST_LIM = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    TAG  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] returned;
  logic [CNT_W-1:0] outstanding;
  logic             issue;
  logic             ret_ok;

  // Request/address decode from registered state only, so mem_addr is stable under backpressure.
  assign mem_req  = (state == FILL) && (issued < LINE_CNT) && (outstanding < OUTST_LIM);
  assign mem_addr = fill_base + ADDR_W'(issued) * ADDR_W'(WORD_BYTES);
  assign issue    = mem_req && mem_ready;

  // Returns with nothing in flight (e.g. left over from an aborted fill) are dropped.
  assign ret_ok       = mem_data_valid && (state == FILL) && (outstanding != '0);
  assign fsm_data_wen = ret_ok;
  assign fsm_word_idx = returned[IDX_W-1:0];
  assign fsm_data     = mem_data;
  assign fsm_tag_wen  = (state == TAG);
  assign fsm_busy     = (state != IDLE) || miss_detected;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      issued      <= '0;
      returned    <= '0;
      outstanding <= '0;
      fill_base   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_detected) begin
            fill_base   <= miss_address & LINE_MASK;
            issued      <= '0;
            returned    <= '0;
            outstanding <= '0;
            state       <= FILL;
          end
        end
        FILL: begin
          if (issue) begin
            issued <= issued + CNT_W'(1);
          end
          if (ret_ok) begin
            returned <= returned + CNT_W'(1);
          end
          if (issue && !ret_ok) begin
            outstanding <= outstanding + CNT_W'(1);
          end else if (!issue && ret_ok) begin
            outstanding <= outstanding - CNT_W'(1);
          end
          if (ret_ok && (returned == LAST_IDX)) begin
            state <= TAG;
          end
        end
        TAG: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: a latency-configurable memory model plus
// address/write scoreboards filled when each miss is presented.
module tb_cache_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        mem_ready;
  logic        mem_data_valid;
  logic [15:0] mem_data;

  logic        req1, busy1, wen1, tag1;
  logic [15:0] addr1, fdata1, fb1;
  logic [2:0]  idx1;
  logic        req2, busy2, wen2, tag2;
  logic [15:0] addr2, fdata2, fb2;
  logic [1:0]  idx2;

  always #5 clk = ~clk;

  cache_fill_ctrl dut1 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_req(req1), .mem_addr(addr1), .mem_ready(mem_ready), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .fsm_busy(busy1), .fsm_data_wen(wen1), .fsm_word_idx(idx1),
    .fsm_data(fdata1), .fsm_tag_wen(tag1), .fill_base(fb1)
  );

  cache_fill_ctrl #(.LINE_WORDS(4), .MAX_OUTST(1)) dut2 (
    .clk(clk), .rst(rst), .miss_detected(miss_detected), .miss_address(miss_address),
    .mem_req(req2), .mem_addr(addr2), .mem_ready(mem_ready), .mem_data_valid(mem_data_valid),
    .mem_data(mem_data), .fsm_busy(busy2), .fsm_data_wen(wen2), .fsm_word_idx(idx2),
    .fsm_data(fdata2), .fsm_tag_wen(tag2), .fill_base(fb2)
  );

  typedef struct {
    int          due;
    logic [15:0] data;
  } rd_t;
  typedef struct {
    int          idx;
    logic [15:0] data;
  } wr_t;

  rd_t         pend[$];
  wr_t         exp_wr[$];
  logic [15:0] exp_addr[$];

  int cyc, n_checks, n_fail;
  int sel, lw, mo, lat, stall_cnt;
  int outst_m, peak, hold_cnt, wen_cnt, tag_cnt;
  int last_wen, tag_cyc, miss_cyc;
  bit active_m, stale, held_valid, fb_pending;
  logic [15:0] held_addr, exp_base;

  logic        o_req, o_busy, o_wen, o_tag;
  logic [15:0] o_addr, o_data, o_fb;
  int          o_idx;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC35A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    if (sel == 0) begin
      o_req = req1; o_busy = busy1; o_wen = wen1; o_tag = tag1;
      o_addr = addr1; o_data = fdata1; o_fb = fb1; o_idx = int'(idx1);
    end else begin
      o_req = req2; o_busy = busy2; o_wen = wen2; o_tag = tag2;
      o_addr = addr2; o_data = fdata2; o_fb = fb2; o_idx = int'(idx2);
    end
  endtask

  // Scoreboard load: expected read addresses and word writes for the line that missed.
  task automatic model_start();
    logic [15:0] base;
    wr_t         w;
    base = miss_address & ~16'(lw * 2 - 1);
    exp_addr.delete();
    exp_wr.delete();
    for (int k = 0; k < lw; k++) begin
      exp_addr.push_back(base + 16'(2 * k));
      w.idx  = k;
      w.data = mem_word(base + 16'(2 * k));
      exp_wr.push_back(w);
    end
    exp_base   = base;
    fb_pending = 1'b1;
    active_m   = 1'b1;
    miss_cyc   = cyc;
    wen_cnt    = 0;
  endtask

  // One clock cycle, entered and left at the falling edge.
  task automatic cycle();
    int          outst_pre;
    rd_t         r;
    wr_t         w;
    logic [15:0] ea;
    mem_ready = (stall_cnt == 0);
    if (stale) begin
      mem_data_valid = 1'b1;
      mem_data       = 16'hDEAD;
    end else if (pend.size() != 0 && pend[0].due <= cyc) begin
      mem_data_valid = 1'b1;
      mem_data       = pend[0].data;
    end else begin
      mem_data_valid = 1'b0;
      mem_data       = 16'h0000;
    end
    #1;
    sample();
    outst_pre = outst_m;
    chk("busy", o_busy, active_m || miss_detected);
    if (fb_pending) begin
      chk("fill_base", o_fb, exp_base);
      fb_pending = 1'b0;
    end
    if (!active_m) chk("req_idle", o_req, 0);

    if (stale) begin
      chk("stale_wen", o_wen, 0);
    end else if (mem_data_valid) begin
      chk("wen", o_wen, 1);
      void'(pend.pop_front());
      outst_m--;
      if (exp_wr.size() != 0) begin
        w = exp_wr.pop_front();
        chk("word_idx", o_idx, w.idx);
        chk("fsm_data", o_data, w.data);
      end else begin
        chk("spurious_return", exp_wr.size(), 1);
      end
      last_wen = cyc;
      wen_cnt++;
    end else begin
      chk("wen_quiet", o_wen, 0);
    end

    if (o_req) begin
      chk("req_outst_limit", outst_pre < mo, 1);
      if (held_valid) chk("addr_hold", o_addr, held_addr);
      if (mem_ready) begin
        if (exp_addr.size() != 0) begin
          ea = exp_addr.pop_front();
          chk("mem_addr", o_addr, ea);
        end else begin
          chk("spurious_issue", exp_addr.size(), 1);
        end
        r.due  = cyc + lat;
        r.data = mem_word(o_addr);
        pend.push_back(r);
        outst_m++;
        held_valid = 1'b0;
      end else begin
        held_valid = 1'b1;
        held_addr  = o_addr;
        hold_cnt++;
      end
    end else if (held_valid) begin
      chk("req_dropped_under_stall", o_req, 1);
      held_valid = 1'b0;
    end
    if (outst_m > peak) peak = outst_m;

    if (o_tag) begin
      chk("tag_after_last_word", cyc, last_wen + 1);
      chk("tag_words_left", exp_wr.size(), 0);
      tag_cnt++;
      tag_cyc  = cyc;
      active_m = 1'b0;
    end else if (!active_m && miss_detected) begin
      model_start();
    end
    if (stall_cnt > 0) stall_cnt--;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic run_until_tag(input int budget);
    int target;
    int b;
    target = tag_cnt + 1;
    b      = budget;
    while (tag_cnt < target && b > 0) begin
      cycle();
      b--;
    end
    chk("fill_done", tag_cnt, target);
  endtask

  task automatic start_fill(input logic [15:0] a);
    miss_detected = 1'b1;
    miss_address  = a;
    cycle();
    miss_detected = 1'b0;
  endtask

  // Asynchronous reset with a return still being presented.
  task automatic pulse_reset(input int n);
    rst            = 1'b1;
    miss_detected  = 1'b0;
    mem_ready      = 1'b1;
    mem_data_valid = 1'b1;
    mem_data       = 16'hBEEF;
    #1;
    sample();
    chk("rst_req", o_req, 0);
    chk("rst_wen", o_wen, 0);
    chk("rst_tag", o_tag, 0);
    chk("rst_addr", o_addr, 0);
    chk("rst_idx", o_idx, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_fill_base", o_fb, 0);
    miss_detected = 1'b1;
    #1;
    sample();
    chk("rst_busy_miss", o_busy, 1);
    miss_detected = 1'b0;
    pend.delete();
    exp_addr.delete();
    exp_wr.delete();
    outst_m    = 0;
    active_m   = 1'b0;
    held_valid = 1'b0;
    fb_pending = 1'b0;
    stall_cnt  = 0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    rst            = 1'b0;
    mem_data_valid = 1'b0;
  endtask

  initial begin
    int b;
    int t1;
    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0000;
    mem_ready = 1'b1; mem_data_valid = 1'b0; mem_data = 16'h0000;
    cyc = 0; n_checks = 0; n_fail = 0;
    sel = 0; lw = 8; mo = 4; lat = 1; stall_cnt = 0;
    outst_m = 0; peak = 0; hold_cnt = 0; wen_cnt = 0; tag_cnt = 0;
    last_wen = -10; tag_cyc = 0; miss_cyc = 0;
    active_m = 1'b0; stale = 1'b0; held_valid = 1'b0; fb_pending = 1'b0;
    held_addr = 16'h0; exp_base = 16'h0;
    @(negedge clk);
    pulse_reset(2);

    // Zero-latency fill: 0x1236 -> line 0x1230, tag ten cycles after the miss.
    start_fill(16'h1236);
    run_until_tag(40);
    chk("fill_latency", tag_cyc - miss_cyc, 10);
    chk("peak_outst_fast", peak, 1);
    repeat (2) cycle();

    // Five cycles of backpressure on the first read.
    hold_cnt  = 0;
    stall_cnt = 6;
    start_fill(16'h1236);
    run_until_tag(60);
    chk("stall_cycles", hold_cnt, 5);
    cycle();

    // Slow memory: outstanding reads capped at MAX_OUTST.
    lat  = 6;
    peak = 0;
    start_fill(16'h0A5E);
    run_until_tag(100);
    chk("peak_outst_slow", peak, 4);
    lat = 1;
    cycle();

    // Line at the top of the address space.
    start_fill(16'hFFF8);
    run_until_tag(40);
    cycle();

    // Reset after three returns, then stale returns, then a fresh fill.
    lat = 3;
    start_fill(16'h5555);
    b = 40;
    while (wen_cnt < 3 && b > 0) begin
      cycle();
      b--;
    end
    chk("three_returns", wen_cnt, 3);
    pulse_reset(2);
    stale = 1'b1;
    repeat (3) cycle();
    stale = 1'b0;
    start_fill(16'h4000);
    run_until_tag(60);
    lat = 1;
    cycle();

    // Four-word line, one read in flight, miss held through TAG.
    pulse_reset(2);
    sel  = 1;
    lw   = 4;
    mo   = 1;
    peak = 0;
    miss_detected = 1'b1;
    miss_address  = 16'h2345;
    cycle();
    run_until_tag(40);
    t1 = tag_cyc;
    run_until_tag(40);
    miss_detected = 1'b0;
    chk("refill_spacing", tag_cyc - t1, 10);
    chk("peak_outst_single", peak, 1);
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
